// File: rtl/cell_sample_collector_pkg.sv
// rtl/cell_sample_collector_pkg.sv - shared constants and FSM state type for the sample collector
package cell_sample_collector_pkg;

   localparam int LANES    = 4;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int MAN_MSB  = 22;

   localparam logic [7:0] EXP_ZERO = 8'h00;
   localparam logic [7:0] EXP_MAX  = 8'hFF;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/cell_sample_collector_fp_lane_check.sv
// rtl/cell_sample_collector_fp_lane_check.sv - flags single-precision words the adder cannot take as normal operands
import cell_sample_collector_pkg::*;

module fp_lane_check #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] word_i,
   output logic            bad_o
);

   logic [7:0] exp_field;
   logic       unused_fields;

   assign exp_field = word_i[EXP_MSB:EXP_LSB];

   // zero/denormal and Inf/NaN both fall outside the adder's normal-operand assumption
   assign bad_o = (exp_field == EXP_ZERO) || (exp_field == EXP_MAX);

   assign unused_fields = ^{word_i[SIGN_BIT], word_i[MAN_MSB:0]};

endmodule

// File: rtl/cell_sample_collector.sv
// rtl/cell_sample_collector.sv - gathers four FP samples into a frame for the 4-input summing stage
import cell_sample_collector_pkg::*;

module cell_sample_collector #(
   parameter int XLEN  = 32,
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [XLEN-1:0]  s_data,
   input  logic             s_sop,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [XLEN-1:0]  m_a,
   output logic [XLEN-1:0]  m_b,
   output logic [XLEN-1:0]  m_c,
   output logic [XLEN-1:0]  m_d,
   output logic [LANES-1:0] m_bad,
   output logic [7:0]       drop_cnt
);

   state_e             state_q, state_d;
   logic [1:0]         lane_q, lane_d;
   logic [XLEN-1:0]    fill_q [LANES];
   logic [XLEN-1:0]    fill_d [LANES];
   logic [LANES-1:0]   fill_bad_q, fill_bad_d;
   logic [XLEN-1:0]    out_q [LANES];
   logic [XLEN-1:0]    out_d [LANES];
   logic [LANES-1:0]   out_bad_q, out_bad_d;
   logic               m_valid_q, m_valid_d;
   logic [7:0]         drop_q, drop_d;

   logic               s_bad;
   logic               s_hs;
   logic               m_hs;

   fp_lane_check #(.XLEN(XLEN)) u_lane_check (
      .word_i (s_data),
      .bad_o  (s_bad)
   );

   assign s_ready = (state_q == ST_FILL) && !rst;
   assign s_hs    = s_valid && s_ready;
   assign m_hs    = m_valid_q && m_ready;

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      fill_d     = fill_q;
      fill_bad_d = fill_bad_q;
      out_d      = out_q;
      out_bad_d  = out_bad_q;
      m_valid_d  = m_valid_q;
      drop_d     = drop_q;

      if (m_hs) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         ST_FILL: begin
            if (s_hs) begin
               if (s_sop && (lane_q != 2'd0)) begin
                  // restart: the partial frame is abandoned and this sample opens a new one
                  fill_d[0]     = s_data;
                  fill_bad_d[0] = s_bad;
                  lane_d        = 2'd1;
                  if (drop_q != 8'hFF) begin
                     drop_d = drop_q + 8'd1;
                  end
               end else begin
                  fill_d[lane_q]     = s_data;
                  fill_bad_d[lane_q] = s_bad;
                  if (lane_q == 2'd3) begin
                     lane_d = 2'd0;
                     if (!m_valid_q || m_ready) begin
                        out_d     = fill_d;
                        out_bad_d = fill_bad_d;
                        m_valid_d = 1'b1;
                     end else begin
                        state_d = ST_HOLD;
                     end
                  end else begin
                     lane_d = lane_q + 2'd1;
                  end
               end
            end
         end
         ST_HOLD: begin
            if (m_hs) begin
               out_d     = fill_q;
               out_bad_d = fill_bad_q;
               m_valid_d = 1'b1;
               state_d   = ST_FILL;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FILL;
         lane_q     <= 2'd0;
         fill_q     <= '{default: '0};
         fill_bad_q <= '0;
         out_q      <= '{default: '0};
         out_bad_q  <= '0;
         m_valid_q  <= 1'b0;
         drop_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         fill_q     <= fill_d;
         fill_bad_q <= fill_bad_d;
         out_q      <= out_d;
         out_bad_q  <= out_bad_d;
         m_valid_q  <= m_valid_d;
         drop_q     <= drop_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_a      = out_q[0];
   assign m_b      = out_q[1];
   assign m_c      = out_q[2];
   assign m_d      = out_q[3];
   assign m_bad    = out_bad_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cell_sample_collector.sv
// tb/tb_cell_sample_collector.sv - directed table-driven bench for cell_sample_collector
module tb_cell_sample_collector;

   localparam logic [31:0] A = 32'h40e9999a;
   localparam logic [31:0] B = 32'h40d9999a;
   localparam logic [31:0] C = 32'h40666666;
   localparam logic [31:0] D = 32'h40266666;
   localparam logic [31:0] E = 32'h3f800000;
   localparam logic [31:0] F = 32'h40000000;
   localparam logic [31:0] G = 32'h40400000;
   localparam logic [31:0] H = 32'h40800000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_sop = 1'b0;
   logic [31:0] s_data = 32'h0;
   logic        m_ready = 1'b0;
   logic        s_ready;
   logic        m_valid;
   logic [31:0] m_a, m_b, m_c, m_d;
   logic [3:0]  m_bad;
   logic [7:0]  drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        sv;
      logic        sop;
      logic [31:0] sd;
      logic        mr;
      logic        e_rdy;
      logic        e_mv;
      logic        chk;
      logic [31:0] ea, eb, ec, ed;
      logic [3:0]  ebad;
      logic [7:0]  edrop;
   } vec_t;

   vec_t vecs[$];

   cell_sample_collector #(.XLEN(32), .LANES(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_sop    (s_sop),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_a      (m_a),
      .m_b      (m_b),
      .m_c      (m_c),
      .m_d      (m_d),
      .m_bad    (m_bad),
      .drop_cnt (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic sv, input logic sop,
                       input logic [31:0] d, input logic mr);
      rst     = r;
      s_valid = sv;
      s_sop   = sop;
      s_data  = d;
      m_ready = mr;
      @(posedge clk);
      #1;
   endtask

   task automatic addn(input logic r, input logic sv, input logic sop, input logic [31:0] d,
                       input logic mr, input logic erdy, input logic emv, input logic [7:0] edrop);
      vec_t v;
      v.rst = r; v.sv = sv; v.sop = sop; v.sd = d; v.mr = mr;
      v.e_rdy = erdy; v.e_mv = emv; v.chk = 1'b0;
      v.ea = '0; v.eb = '0; v.ec = '0; v.ed = '0; v.ebad = '0; v.edrop = edrop;
      vecs.push_back(v);
   endtask

   task automatic addf(input logic r, input logic sv, input logic sop, input logic [31:0] d,
                       input logic mr, input logic erdy, input logic emv,
                       input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                       input logic [31:0] ed, input logic [3:0] ebad, input logic [7:0] edrop);
      vec_t v;
      v.rst = r; v.sv = sv; v.sop = sop; v.sd = d; v.mr = mr;
      v.e_rdy = erdy; v.e_mv = emv; v.chk = 1'b1;
      v.ea = ea; v.eb = eb; v.ec = ec; v.ed = ed; v.ebad = ebad; v.edrop = edrop;
      vecs.push_back(v);
   endtask

   task automatic check_frame(input string nm, input logic [31:0] ea, input logic [31:0] eb,
                              input logic [31:0] ec, input logic [31:0] ed, input logic [3:0] ebad);
      chk({nm, " m_a"}, m_a, ea);
      chk({nm, " m_b"}, m_b, eb);
      chk({nm, " m_c"}, m_c, ec);
      chk({nm, " m_d"}, m_d, ed);
      chk({nm, " m_bad"}, {28'h0, m_bad}, {28'h0, ebad});
   endtask

   initial begin
      // reset state and a basic frame
      addf(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 8'd0);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd0);
      addn(0, 1, 0, A, 1, 1, 0, 8'd0);
      addn(0, 1, 0, B, 1, 1, 0, 8'd0);
      addn(0, 1, 0, C, 1, 1, 0, 8'd0);
      addf(0, 1, 0, D, 1, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd0);
      // backpressure: second frame parks in the fill buffer
      addn(0, 1, 0, A, 0, 1, 0, 8'd0);
      addn(0, 1, 0, B, 0, 1, 0, 8'd0);
      addn(0, 1, 0, C, 0, 1, 0, 8'd0);
      addf(0, 1, 0, D, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      for (int k = 0; k < 10; k++) addf(0, 0, 0, 0, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, E, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, F, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, G, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, H, 0, 0, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 1, 32'h12345678, 0, 0, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 0, 0, 0, 1, 1, 1, E, F, G, H, 4'h0, 8'd0);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd0);
      // streaming with m_ready high, then a same-cycle drain on completion
      addn(0, 1, 0, E, 1, 1, 0, 8'd0);
      addn(0, 1, 0, F, 1, 1, 0, 8'd0);
      addn(0, 1, 0, G, 1, 1, 0, 8'd0);
      addf(0, 1, 0, H, 1, 1, 1, E, F, G, H, 4'h0, 8'd0);
      addn(0, 1, 0, A, 1, 1, 0, 8'd0);
      addn(0, 1, 0, B, 1, 1, 0, 8'd0);
      addn(0, 1, 0, C, 1, 1, 0, 8'd0);
      addf(0, 1, 0, D, 1, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, E, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, F, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, G, 0, 1, 1, A, B, C, D, 4'h0, 8'd0);
      addf(0, 1, 0, H, 1, 1, 1, E, F, G, H, 4'h0, 8'd0);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd0);
      // sop mid-frame truncates the partial frame
      addn(0, 1, 1, 32'h3f800000, 1, 1, 0, 8'd0);
      addn(0, 1, 0, 32'h40000000, 1, 1, 0, 8'd0);
      addn(0, 1, 1, 32'h40400000, 1, 1, 0, 8'd1);
      addn(0, 1, 0, 32'h40800000, 1, 1, 0, 8'd1);
      addn(0, 1, 0, 32'h40a00000, 1, 1, 0, 8'd1);
      addf(0, 1, 0, 32'h40c00000, 1, 1, 1,
           32'h40400000, 32'h40800000, 32'h40a00000, 32'h40c00000, 4'h0, 8'd1);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd1);
      // special-exponent flags, data passed through untouched
      addn(0, 1, 1, 32'h00000000, 1, 1, 0, 8'd1);
      addn(0, 1, 0, 32'h7f800000, 1, 1, 0, 8'd1);
      addn(0, 1, 0, 32'h7fc00000, 1, 1, 0, 8'd1);
      addf(0, 1, 0, 32'h3f800000, 1, 1, 1,
           32'h00000000, 32'h7f800000, 32'h7fc00000, 32'h3f800000, 4'b0111, 8'd1);
      addn(0, 0, 0, 0, 1, 1, 0, 8'd1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].sv, vecs[i].sop, vecs[i].sd, vecs[i].mr);
         chk($sformatf("v%0d s_ready", i), {31'h0, s_ready}, {31'h0, vecs[i].e_rdy});
         chk($sformatf("v%0d m_valid", i), {31'h0, m_valid}, {31'h0, vecs[i].e_mv});
         chk($sformatf("v%0d drop_cnt", i), {24'h0, drop_cnt}, {24'h0, vecs[i].edrop});
         if (vecs[i].chk)
            check_frame($sformatf("v%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec,
                        vecs[i].ed, vecs[i].ebad);
      end

      // drop counter saturation over 256 truncated frames
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 32'h3f800000, 1);
      for (int k = 1; k <= 256; k++) begin
         step(0, 1, 1, 32'h3f800000 + k, 1);
         if (k == 1)   chk("drop first", {24'h0, drop_cnt}, 32'd1);
         if (k == 255) chk("drop 255", {24'h0, drop_cnt}, 32'd255);
      end
      chk("drop saturated", {24'h0, drop_cnt}, 32'd255);
      chk("sat no frame", {31'h0, m_valid}, 32'd0);

      // reset mid-frame
      step(0, 1, 0, A, 0);
      step(1, 0, 0, 0, 0);
      chk("rst mid s_ready", {31'h0, s_ready}, 32'd0);
      chk("rst mid m_valid", {31'h0, m_valid}, 32'd0);
      chk("rst mid drop", {24'h0, drop_cnt}, 32'd0);
      check_frame("rst mid", 0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 1);
      chk("post rst1 s_ready", {31'h0, s_ready}, 32'd1);
      chk("post rst1 m_valid", {31'h0, m_valid}, 32'd0);

      // reset while holding two frames
      step(0, 1, 0, A, 0);
      step(0, 1, 0, B, 0);
      step(0, 1, 0, C, 0);
      step(0, 1, 0, D, 0);
      step(0, 1, 0, E, 0);
      step(0, 1, 0, F, 0);
      step(0, 1, 0, G, 0);
      step(0, 1, 0, H, 0);
      chk("hold s_ready", {31'h0, s_ready}, 32'd0);
      chk("hold m_valid", {31'h0, m_valid}, 32'd1);
      step(1, 0, 0, 0, 0);
      chk("rst hold s_ready", {31'h0, s_ready}, 32'd0);
      chk("rst hold m_valid", {31'h0, m_valid}, 32'd0);
      check_frame("rst hold", 0, 0, 0, 0, 4'h0);
      step(0, 0, 0, 0, 1);
      chk("post rst2 m_valid", {31'h0, m_valid}, 32'd0);
      chk("post rst2 s_ready", {31'h0, s_ready}, 32'd1);
      step(0, 1, 0, E, 1);
      step(0, 1, 0, F, 1);
      step(0, 1, 0, G, 1);
      chk("refill early m_valid", {31'h0, m_valid}, 32'd0);
      step(0, 1, 0, H, 1);
      chk("refill m_valid", {31'h0, m_valid}, 32'd1);
      check_frame("refill", E, F, G, H, 4'h0);
      step(0, 0, 0, 0, 1);
      chk("refill drained", {31'h0, m_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cell_sample_collector.md
CELL_SAMPLE_COLLECTOR -- requirements
Module: cell_sample_collector

Interface
REQ-001 SHALL have parameter XLEN, default 32, IEEE-754 single-precision word width (only 32 supported).
REQ-002 SHALL have parameter LANES, default 4, samples per frame (fixed 4; matches the 4-input FP summing stage).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  upstream sample valid.
REQ-006 s_ready  output  1  collector can accept a sample.
REQ-007 s_data  input  XLEN  cell reading, IEEE-754 single.
REQ-008 s_sop  input  1  sample is lane 0 of a new frame.
REQ-009 m_valid  output  1  frame available to summing stage.
REQ-010 m_ready  input  1  summing stage accepts frame.
REQ-011 m_a, m_b, m_c, m_d  output  XLEN each  lanes 0..3 of frame, to adder A/B/C/D.
REQ-012 m_bad  output  LANES  per-lane flag: exponent field 0x00 or 0xFF (zero/denormal/Inf/NaN; adder assumes normal operands).
REQ-013 drop_cnt  output  8  count of partial frames discarded, saturating.

Function
REQ-014 Sample handshake = s_valid && s_ready; frame handshake = m_valid && m_ready.
REQ-015 Accepted samples SHALL fill lanes in order 0,1,2,3 via 2-bit lane counter; counter wraps to 0 after lane 3.
REQ-016 FSM states: FILL (lane counter 0..3, s_ready=1), HOLD (fill buffer complete, output register occupied, s_ready=0).
REQ-017 On 4th sample accepted: if output register empty or frame handshake same cycle, frame SHALL move to output register, m_valid=1 next cycle, stay FILL; else go HOLD.
REQ-018 HOLD -> FILL on frame handshake; buffered frame loads output register same edge, m_valid stays 1.
REQ-019 Latency: m_valid rises exactly 1 cycle after the 4th sample handshake when output path free.
REQ-020 Throughput: with m_ready held 1, SHALL sustain one sample per cycle with no s_ready deassertion.
REQ-021 m_a..m_d, m_bad SHALL be stable while m_valid=1 and m_ready=0.
REQ-022 m_bad[i] computed from lane i at capture, registered alongside data; data passed unmodified.
REQ-023 s_sop accepted with lane counter 0: normal lane 0. s_sop accepted with counter 1..3: discard partial lanes, sample becomes lane 0, counter=1, drop_cnt+1 (saturate at 255).
REQ-024 s_sop=0 on first sample after reset or after a completed frame: still lane 0, no error.
REQ-025 s_sop ignored when s_valid=0 or s_ready=0.
REQ-026 Output register and fill buffer SHALL never lose a completed frame; only partial frames are discarded.

Reset
REQ-027 While rst=1: s_ready=0, m_valid=0, m_a..m_d=0, m_bad=0, drop_cnt=0, lane counter=0, state FILL.
REQ-028 Cycle after rst deasserts: s_ready=1.
REQ-029 rst mid-frame or in HOLD SHALL discard all buffered and output data without emitting a frame.

Structure
REQ-030 Shared package SHALL hold LANES, FP field constants (SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22), EXP_ZERO=8'h00, EXP_MAX=8'hFF, FSM state enum.
REQ-031 One sub-module fp_lane_check: combinational, input XLEN word, output 1-bit bad flag; instantiated once on s_data.
REQ-032 Target 150-300 lines RTL total.

Verification
REQ-033 Reset then 4 samples 40e9999a, 40d9999a, 40666666, 40266666 back-to-back, m_ready=1 -> m_valid 1 cycle after 4th; m_a..m_d equal inputs in order; m_bad=0000.
REQ-034 Same 4 samples, m_ready=0 for 10 cycles, then 4 more samples -> second frame enters fill buffer, HOLD, s_ready=0; after m_ready=1, both frames delivered intact in order.
REQ-035 Samples 3f800000, 40000000, then s_sop with 40400000 -> drop_cnt=1; frame completes with 40400000 as m_a.
REQ-036 Frame 00000000, 7f800000, 7fc00000, 3f800000 -> m_bad=0111 (bit i = lane i), data unmodified.
REQ-037 256 sop-truncated partial frames -> drop_cnt saturates at 255.
REQ-038 rst asserted after 2 samples, and again in HOLD -> no frame emitted; all outputs per REQ-027; next 4 samples form lanes 0..3.
